// File: rtl/dcm_prog_ctrl_pkg.sv
// Shared definitions for the dcm programming controller: FSM states, mode codes
// and the default timing values that the dcm block also uses.
package dcm_prog_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EDIT     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    MODE_0 = 3'd0,
    MODE_1 = 3'd1,
    MODE_2 = 3'd2,
    MODE_3 = 3'd3,
    MODE_4 = 3'd4,
    MODE_5 = 3'd5,
    MODE_6 = 3'd6,
    MODE_7 = 3'd7
  } mode_e;

  localparam int unsigned DEF_EDIT_TIMEOUT = 500_000_000;
  localparam int unsigned DEF_ACK_TIMEOUT  = 16;
  localparam int unsigned DEF_MAX_RETRY    = 3;

  // Modulo-8 step of the selection; wrap comes from the 3-bit width.
  function automatic logic [2:0] sel_step(input logic [2:0] cur, input logic up);
    return up ? cur + 3'd1 : cur - 3'd1;
  endfunction

endpackage

// File: rtl/dcm_prog_ctrl_edge_detector.sv
// Rising-edge detector for a debounced, clk-synchronous button level.
// The pulse is registered, so it appears the cycle after the level rises.
module dcm_prog_ctrl_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_q <= in;
      rise    <= in & ~level_q;
    end
  end

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Sequences clk_2 mode changes of the dcm: button editing, strobe issue,
// acknowledge watch with timeout/retry, and sticky error reporting.
//
// state       | meaning
// ST_IDLE     | showing active mode, waiting for up/down
// ST_EDIT     | user editing sel; inactivity timer running
// ST_ISSUE    | one-cycle dcm_update strobe with dcm_prog_in
// ST_WAIT_ACK | waiting for dcm_prog_out to match dcm_prog_in
// ST_ERROR    | retries exhausted; err held until apply
module dcm_prog_ctrl
  import dcm_prog_ctrl_pkg::*;
#(
  parameter int unsigned EDIT_TIMEOUT = DEF_EDIT_TIMEOUT,
  parameter int unsigned ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
  parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY,
  parameter logic [2:0]  DEFAULT_MODE = MODE_0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_apply,
  input  logic [2:0] dcm_prog_out,
  output logic       dcm_update,
  output logic [2:0] dcm_prog_in,
  output logic [2:0] sel,
  output logic [2:0] active,
  output logic       busy,
  output logic       err
);

  localparam int ACK_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  // One extra count so retry_cnt can hold MAX_RETRY itself.
  localparam int RETRY_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [ACK_W-1:0]   ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [31:0]        EDIT_LAST = 32'(EDIT_TIMEOUT - 1);

  logic up_p, down_p, apply_p, step_p;

  state_e             state, state_d;
  logic [2:0]         sel_d, active_d, prog_in_d;
  logic               err_d, update_d;
  logic [31:0]        inact_cnt, inact_d;
  logic [ACK_W-1:0]   ack_cnt, ack_d;
  logic [RETRY_W-1:0] retry_cnt, retry_d;

  dcm_prog_ctrl_edge_detector u_ed_up    (.clk(clk), .rst(rst), .in(btn_up),    .rise(up_p));
  dcm_prog_ctrl_edge_detector u_ed_down  (.clk(clk), .rst(rst), .in(btn_down),  .rise(down_p));
  dcm_prog_ctrl_edge_detector u_ed_apply (.clk(clk), .rst(rst), .in(btn_apply), .rise(apply_p));

  // Simultaneous up and down cancel out.
  assign step_p = up_p ^ down_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      sel         <= DEFAULT_MODE;
      active      <= DEFAULT_MODE;
      dcm_prog_in <= DEFAULT_MODE;
      err         <= 1'b0;
      dcm_update  <= 1'b0;
      inact_cnt   <= '0;
      ack_cnt     <= '0;
      retry_cnt   <= '0;
    end else begin
      state       <= state_d;
      sel         <= sel_d;
      active      <= active_d;
      dcm_prog_in <= prog_in_d;
      err         <= err_d;
      dcm_update  <= update_d;
      inact_cnt   <= inact_d;
      ack_cnt     <= ack_d;
      retry_cnt   <= retry_d;
    end
  end

  always_comb begin
    state_d   = state;
    sel_d     = sel;
    active_d  = active;
    prog_in_d = dcm_prog_in;
    err_d     = err;
    inact_d   = inact_cnt;
    ack_d     = ack_cnt;
    retry_d   = retry_cnt;

    case (state)
      ST_IDLE: begin
        if (step_p) begin
          sel_d   = sel_step(sel, up_p);
          inact_d = '0;
          state_d = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (apply_p) begin
          if (sel == active) begin
            state_d = ST_IDLE;
          end else begin
            prog_in_d = sel;
            retry_d   = '0;
            state_d   = ST_ISSUE;
          end
        end else if (step_p) begin
          sel_d   = sel_step(sel, up_p);
          inact_d = '0;
        end else if (inact_cnt == EDIT_LAST) begin
          sel_d   = active;
          state_d = ST_IDLE;
        end else begin
          inact_d = inact_cnt + 32'd1;
        end
      end
      ST_ISSUE: begin
        ack_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (dcm_prog_out == dcm_prog_in) begin
          active_d = dcm_prog_in;
          state_d  = ST_IDLE;
        end else if (ack_cnt == ACK_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_d = retry_cnt + RETRY_W'(1);
            state_d = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end else begin
          ack_d = ack_cnt + ACK_W'(1);
        end
      end
      ST_ERROR: begin
        if (apply_p) begin
          err_d   = 1'b0;
          sel_d   = active;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobe is registered alongside the state so it is high exactly while in ISSUE.
    update_d = (state_d == ST_ISSUE);
  end

  assign busy = (state == ST_ISSUE) || (state == ST_WAIT_ACK);

endmodule
